// File: rtl/move_sequencer.sv
// move_sequencer: queues signed relative-angle moves and hands them to
// angle_to_step one at a time over the enable/done handshake, with an
// enforced settle dwell between moves.
module move_sequencer #(
  parameter int SIZE          = 64,
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 25000,
  parameter int ACK_TIMEOUT   = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [SIZE-1:0]          cmd_angle_i,
  input  logic                     abort_i,
  output logic [SIZE-1:0]          angle_o,
  output logic                     dir_o,
  output logic                     enable_o,
  input  logic                     done_i,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic [15:0]              moves_done_o,
  output logic                     err_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int TMAX = (SETTLE_CYCLES > ACK_TIMEOUT) ? SETTLE_CYCLES : ACK_TIMEOUT;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] ACK_LAST    = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [AW:0]   FULL_CNT    = (AW+1)'(DEPTH);

  typedef struct packed {
    logic            dir;
    logic [SIZE-2:0] mag;
  } cmd_t;

  typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, SETTLE} state_t;

  cmd_t [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             push, pop, full;
  cmd_t             head;

  state_t           state, state_d;
  logic [TW-1:0]    tmr, tmr_d;
  logic             enable_d, dir_d, err_d;
  logic [SIZE-1:0]  angle_d;
  logic [15:0]      moves_d;

  assign full         = (count == FULL_CNT);
  assign cmd_ready_o  = !full;
  assign push         = cmd_valid_i && !full && !abort_i;
  assign head         = mem[rd_ptr];
  assign fifo_count_o = count;
  assign busy_o       = (state != IDLE) || (count != '0);

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= cmd_angle_i;
  end

  // FIFO pointers and occupancy; abort flushes everything
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      tmr          <= '0;
      enable_o     <= 1'b0;
      angle_o      <= '0;
      dir_o        <= 1'b0;
      moves_done_o <= '0;
      err_o        <= 1'b0;
    end else begin
      state        <= state_d;
      tmr          <= tmr_d;
      enable_o     <= enable_d;
      angle_o      <= angle_d;
      dir_o        <= dir_d;
      moves_done_o <= moves_d;
      err_o        <= err_d;
    end
  end

  // Next state and next output values; abort overrides every state.
  // enable is raised one cycle after entering ARM so angle/dir lead it,
  // and the acknowledge is only accepted once enable is actually high.
  always_comb begin
    state_d  = state;
    tmr_d    = tmr;
    enable_d = enable_o;
    angle_d  = angle_o;
    dir_d    = dir_o;
    moves_d  = moves_done_o;
    err_d    = err_o;
    pop      = 1'b0;
    if (abort_i) begin
      enable_d = 1'b0;
      err_d    = 1'b0;
      tmr_d    = '0;
      state_d  = SETTLE;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) state_d = LOAD;
        end
        LOAD: begin
          pop     = 1'b1;
          angle_d = {1'b0, head.mag};
          dir_d   = head.dir;
          tmr_d   = '0;
          if (head.mag == '0) begin
            moves_d = moves_done_o + 16'd1;
            state_d = IDLE;
          end else begin
            state_d = ARM;
          end
        end
        ARM: begin
          enable_d = 1'b1;
          if (enable_o && !done_i) begin
            state_d = RUN;
          end else if (tmr == ACK_LAST) begin
            err_d    = 1'b1;
            enable_d = 1'b0;
            tmr_d    = '0;
            state_d  = SETTLE;
          end else begin
            tmr_d = tmr + 1'b1;
          end
        end
        RUN: begin
          if (done_i) begin
            enable_d = 1'b0;
            moves_d  = moves_done_o + 16'd1;
            tmr_d    = '0;
            state_d  = SETTLE;
          end
        end
        SETTLE: begin
          enable_d = 1'b0;
          if (tmr == SETTLE_LAST) begin
            tmr_d   = '0;
            state_d = IDLE;
          end else begin
            tmr_d = tmr + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: directed moves against a queue model of expected moves,
// with an angle_to_step responder and per-cycle handshake monitoring.
module tb_move_sequencer;

  localparam int SIZE    = 64;
  localparam int DEPTH   = 4;
  localparam int SETTLE  = 20;
  localparam int ACKTO   = 16;
  localparam int ACK_DLY = 2;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            cmd_valid_i = 1'b0;
  logic            cmd_ready_o;
  logic [SIZE-1:0] cmd_angle_i = '0;
  logic            abort_i = 1'b0;
  logic [SIZE-1:0] angle_o;
  logic            dir_o;
  logic            enable_o;
  logic            done_i = 1'b1;
  logic            busy_o;
  logic [2:0]      fifo_count_o;
  logic [15:0]     moves_done_o;
  logic            err_o;

  move_sequencer #(.SIZE(SIZE), .DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE), .ACK_TIMEOUT(ACKTO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_angle_i(cmd_angle_i), .abort_i(abort_i), .angle_o(angle_o), .dir_o(dir_o),
    .enable_o(enable_o), .done_i(done_i), .busy_o(busy_o), .fifo_count_o(fifo_count_o),
    .moves_done_o(moves_done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // model: commands expected to become real moves, in order
  logic [SIZE-1:0] exp_q[$];
  int              rises = 0;
  int              falls = 0;
  int              last_high = 0;
  logic [SIZE-1:0] rise_angle = '0;
  logic            rise_dir = 1'b0;

  // responder knobs
  logic ack_mode = 1'b1;
  int   run_len  = 30;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_true(input string name, input logic cond, input int act);
    checks++;
    if (cond !== 1'b1) begin
      errors++;
      $display("FAIL %s actual=%0d", name, act);
    end
  endtask

  function automatic logic [SIZE:0] expect_move(input logic [SIZE-1:0] cmd);
    return {cmd[SIZE-1], 1'b0, cmd[SIZE-2:0]};
  endfunction

  // angle_to_step responder: done falls ACK_DLY cycles after enable, rises run_len later
  initial begin
    int phase = 0;
    int cnt = 0;
    forever begin
      @(posedge clk_i); #1;
      if (!rst_ni) begin
        done_i = 1'b1; phase = 0;
      end else begin
        case (phase)
          0: if (enable_o && ack_mode) begin phase = 1; cnt = 1; end
          1: if (!enable_o) phase = 0;
             else if (cnt >= ACK_DLY) begin done_i = 1'b0; phase = 2; cnt = 0; end
             else cnt++;
          2: if (!enable_o) begin done_i = 1'b1; phase = 0; end
             else if (cnt >= run_len - 1) begin done_i = 1'b1; phase = 3; end
             else cnt++;
          default: if (!enable_o) phase = 0;
        endcase
      end
    end
  end

  // per-cycle compare against the model and handshake rules
  initial begin
    logic            prev_en = 1'b0;
    logic            had_fall = 1'b0;
    logic [SIZE-1:0] prev_angle = '0;
    logic            prev_dir = 1'b0;
    logic [SIZE-1:0] e;
    int low_cnt = 0;
    int hi_cnt = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        prev_en = 1'b0; had_fall = 1'b0; low_cnt = 0; hi_cnt = 0;
        prev_angle = '0; prev_dir = 1'b0;
      end else begin
        check("angle_msb", {63'b0, angle_o[SIZE-1]}, 64'd0);
        check("ready_vs_count", {63'b0, cmd_ready_o}, {63'b0, (fifo_count_o < 3'(DEPTH))});
        if (enable_o && !prev_en) begin
          rises++;
          check("setup_angle", angle_o, prev_angle);
          check("setup_dir", {63'b0, dir_o}, {63'b0, prev_dir});
          if (exp_q.size() == 0) begin
            check_true("unexpected_move", 1'b0, rises);
          end else begin
            e = exp_q.pop_front();
            check("move_angle", angle_o, expect_move(e)[SIZE-1:0]);
            check("move_dir", {63'b0, dir_o}, {63'b0, expect_move(e)[SIZE]});
          end
          if (had_fall) check_true("settle_gap", low_cnt >= SETTLE, low_cnt);
          rise_angle = angle_o; rise_dir = dir_o; hi_cnt = 1;
        end else if (enable_o && prev_en) begin
          check("hold_angle", angle_o, prev_angle);
          check("hold_dir", {63'b0, dir_o}, {63'b0, prev_dir});
          hi_cnt++;
        end else if (!enable_o && prev_en) begin
          had_fall = 1'b1; low_cnt = 1; last_high = hi_cnt; falls++;
        end else begin
          low_cnt++;
        end
        prev_en = enable_o; prev_angle = angle_o; prev_dir = dir_o;
      end
    end
  end

  task automatic push(input logic [SIZE-1:0] a);
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b1; cmd_angle_i = a;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_rises(input int target, input int budget, input string name);
    int n = 0;
    while (rises < target && n < budget) begin @(negedge clk_i); n++; end
    check_true(name, rises >= target, rises);
  endtask

  task automatic wait_falls(input int target, input int budget, input string name);
    int n = 0;
    while (falls < target && n < budget) begin @(negedge clk_i); n++; end
    check_true(name, falls >= target, falls);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    @(negedge clk_i);
    while ((busy_o || enable_o) && n < budget) begin @(negedge clk_i); n++; end
    check_true(name, !busy_o && !enable_o, n);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    int r0;
    int n;
    // reset values
    cycles(3);
    check("rst_ready", {63'b0, cmd_ready_o}, 64'd1);
    check("rst_enable", {63'b0, enable_o}, 64'd0);
    check("rst_angle", angle_o, 64'd0);
    check("rst_moves", {48'b0, moves_done_o}, 64'd0);
    check("rst_err", {63'b0, err_o}, 64'd0);
    check("rst_busy", {63'b0, busy_o}, 64'd0);
    @(posedge clk_i); #1; rst_ni = 1'b1;
    cycles(2);
    check("post_rst_count", {61'b0, fifo_count_o}, 64'd0);

    // +10.0, long run
    run_len = 500;
    exp_q.push_back(64'h0000000A_00000000);
    push(64'h0000000A_00000000);
    wait_rises(1, 50, "t1_rise");
    wait_falls(1, 700, "t1_fall");
    check("t1_angle", rise_angle, 64'h0000000A_00000000);
    check("t1_dir", {63'b0, rise_dir}, 64'd0);
    check_true("t1_high_len", last_high >= 495 && last_high <= 510, last_high);
    wait_idle(100, "t1_idle");
    check("t1_moves", {48'b0, moves_done_o}, 64'd1);

    // -3.5
    run_len = 30;
    exp_q.push_back(64'h80000003_80000000);
    push(64'h80000003_80000000);
    wait_rises(2, 50, "t2_rise");
    check("t2_angle", rise_angle, 64'h00000003_80000000);
    check("t2_dir", {63'b0, rise_dir}, 64'd1);
    wait_idle(200, "t2_idle");
    check("t2_moves", {48'b0, moves_done_o}, 64'd2);

    // fill FIFO while a move runs: 4 accepted, 5th dropped
    run_len = 200;
    exp_q.push_back(64'h00000001_00000000);
    push(64'h00000001_00000000);
    wait_rises(3, 50, "t3_rise");
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(64'h00000002_00000000 + 64'(i));
      push(64'h00000002_00000000 + 64'(i));
    end
    @(negedge clk_i);
    check("t3_count_full", {61'b0, fifo_count_o}, 64'd4);
    check("t3_ready_low", {63'b0, cmd_ready_o}, 64'd0);
    push(64'h00000009_00000000);
    @(negedge clk_i);
    check("t3_count_after_drop", {61'b0, fifo_count_o}, 64'd4);
    wait_idle(2500, "t3_idle");
    check("t3_moves", {48'b0, moves_done_o}, 64'd7);
    check("t3_rises", 64'(rises), 64'd7);

    // acknowledge timeout
    ack_mode = 1'b0;
    exp_q.push_back(64'h00000004_00000000);
    push(64'h00000004_00000000);
    n = 0;
    while (!err_o && n < 200) begin @(negedge clk_i); n++; end
    check("t4_err", {63'b0, err_o}, 64'd1);
    check("t4_enable", {63'b0, enable_o}, 64'd0);
    check("t4_moves", {48'b0, moves_done_o}, 64'd7);
    @(negedge clk_i);
    check_true("t4_high_len", last_high >= 1 && last_high <= ACKTO, last_high);
    wait_idle(100, "t4_idle");
    check("t4_err_sticky", {63'b0, err_o}, 64'd1);
    ack_mode = 1'b1;

    // abort in RUN with two queued, plus a push in the abort cycle
    exp_q.push_back(64'h00000005_00000000);
    push(64'h00000005_00000000);
    wait_rises(9, 50, "t5_rise");
    check("t5_err_not_blocking", {63'b0, err_o}, 64'd1);
    push(64'h00000006_00000000);
    push(64'h00000007_00000000);
    cycles(6);
    check("t5_queued", {61'b0, fifo_count_o}, 64'd2);
    @(posedge clk_i); #1;
    abort_i = 1'b1; cmd_valid_i = 1'b1; cmd_angle_i = 64'h00000008_00000000;
    @(posedge clk_i); #1;
    abort_i = 1'b0; cmd_valid_i = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    check("t5_enable", {63'b0, enable_o}, 64'd0);
    check("t5_count", {61'b0, fifo_count_o}, 64'd0);
    check("t5_err", {63'b0, err_o}, 64'd0);
    check("t5_busy_settle", {63'b0, busy_o}, 64'd1);
    wait_idle(100, "t5_idle");
    check("t5_moves", {48'b0, moves_done_o}, 64'd7);
    check("t5_rises", 64'(rises), 64'd9);

    // zero magnitudes, both signs: counted, never enabled
    r0 = rises;
    push(64'h00000000_00000000);
    push(64'h80000000_00000000);
    wait_idle(100, "t6_idle");
    check("t6_no_enable", 64'(rises), 64'(r0));
    check("t6_moves", {48'b0, moves_done_o}, 64'd9);

    // reset mid-RUN
    run_len = 200;
    exp_q.push_back(64'h0000000B_00000000);
    push(64'h0000000B_00000000);
    wait_rises(10, 50, "t7_rise");
    cycles(10);
    @(posedge clk_i); #2;
    rst_ni = 1'b0;
    #1;
    check("t7_enable", {63'b0, enable_o}, 64'd0);
    check("t7_angle", angle_o, 64'd0);
    check("t7_dir", {63'b0, dir_o}, 64'd0);
    check("t7_moves", {48'b0, moves_done_o}, 64'd0);
    check("t7_busy", {63'b0, busy_o}, 64'd0);
    check("t7_ready", {63'b0, cmd_ready_o}, 64'd1);
    exp_q.delete();
    cycles(2);
    @(posedge clk_i); #1; rst_ni = 1'b1;

    // recovery after reset
    run_len = 20;
    exp_q.push_back(64'h8000000C_00000000);
    push(64'h8000000C_00000000);
    wait_rises(11, 50, "t8_rise");
    check("t8_dir", {63'b0, rise_dir}, 64'd1);
    wait_idle(200, "t8_idle");
    check("t8_moves", {48'b0, moves_done_o}, 64'd1);
    check("t8_model_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=0", 1);
    $fatal(1, "timeout");
  end

endmodule
